// File: rtl/serial_subtractor4_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding is fixed so external probes can decode it.
package serial_subtractor4_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned DEFAULT_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bits needed for a counter that must reach `width - 1`.
   function automatic int unsigned cnt_bits(input int unsigned width);
      int unsigned n;
      n = 1;
      while ((32'd1 << n) < width) begin
         n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/serial_subtractor4_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// master: controller side; slave: subtractor side.
interface serial_subtractor4_if #(
   parameter int unsigned WIDTH = 4
);

   logic             start;
   logic [WIDTH-1:0] in_1;
   logic [WIDTH-1:0] in_2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             borrow;

   modport master (
      output start,
      output in_1,
      output in_2,
      input  busy,
      input  done,
      input  out,
      input  borrow
   );

   modport slave (
      input  start,
      input  in_1,
      input  in_2,
      output busy,
      output done,
      output out,
      output borrow
   );

endinterface

// File: rtl/full_subtractor1.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, bout = borrow out.
module full_subtractor1 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_diff,
   output logic o_bout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_diff = w_axb ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: one full-subtractor cell reused per cycle, LSB first.
// Result and borrow are published only when the last bit is processed.
module serial_subtractor4
   import serial_subtractor4_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor4_if.slave  bus
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_b_nxt;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] w_res_nxt;
   logic             r_bin;
   logic             w_bin_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] w_out_nxt;
   logic             r_borrow;
   logic             w_borrow_nxt;

   logic             w_diff;
   logic             w_bout;
   logic             w_last;
   logic [WIDTH-1:0] w_res_shift;

   full_subtractor1 u_cell (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_bin  (r_bin),
      .o_diff (w_diff),
      .o_bout (w_bout)
   );

   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
   // Each diff bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
   assign w_res_shift = {w_diff, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_res_nxt    = r_res;
      w_bin_nxt    = r_bin;
      w_cnt_nxt    = r_cnt;
      w_out_nxt    = r_out;
      w_borrow_nxt = r_borrow;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_a_nxt     = bus.in_1;
               w_b_nxt     = bus.in_2;
               w_res_nxt   = '0;
               w_bin_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_a_nxt   = {1'b0, r_a[WIDTH-1:1]};
            w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
            w_res_nxt = w_res_shift;
            w_bin_nxt = w_bout;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_last) begin
               w_out_nxt    = w_res_shift;
               w_borrow_nxt = w_bout;
               w_state_nxt  = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
         r_out    <= '0;
         r_borrow <= 1'b0;
      end else begin
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_res    <= w_res_nxt;
         r_bin    <= w_bin_nxt;
         r_cnt    <= w_cnt_nxt;
         r_out    <= w_out_nxt;
         r_borrow <= w_borrow_nxt;
      end
   end

   // Outputs come straight from registers; no input reaches them combinationally.
   assign bus.busy   = (r_state == ST_RUN);
   assign bus.done   = (r_state == ST_DONE);
   assign bus.out    = r_out;
   assign bus.borrow = r_borrow;

   a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
      (r_state == ST_DONE) |=> (r_state == ST_IDLE));
   a_state_legal : assert property (@(posedge clk) disable iff (rst)
      (r_state inside {ST_IDLE, ST_RUN, ST_DONE}));
   a_cnt_bounded : assert property (@(posedge clk) disable iff (rst)
      (r_state == ST_RUN) |-> (r_cnt <= CNT_W'(WIDTH - 1)));

endmodule
